// File: rtl/axil_pm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_pm_pkg
// Brief    : Shared types and AXI4-Lite constants for axil_pattern_master.
// Revision : 1.0
// ============================================================================
package axil_pm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } pm_state_e;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/axil_pm_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : axil_pm_watchdog
// Brief    : Stall counter; o_expired pulses on the C_LIMIT-th enabled cycle
//            since the last clear.
// Revision : 1.0
// ============================================================================
module axil_pm_watchdog #(
    parameter int C_LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(C_LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign o_expired = i_en & ~i_clr & (count_q == CNT_W'(C_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_pattern_master.sv
`default_nettype none
// ============================================================================
// Module   : axil_pattern_master
// Brief    : AXI4-Lite initiator: writes C_SEED+i to word i of a window, reads
//            the window back and flags mismatches/error responses on ERROR.
//            Optional watchdog enabled by the macro AXIL_PM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module axil_pattern_master
    import axil_pm_pkg::*;
#(
    parameter int          C_ADDR_WIDTH     = 32,
    parameter int          C_DATA_WIDTH     = 32,
    parameter int          C_NUM_WORDS      = 4,
    parameter logic [31:0] C_BASE_ADDR      = 32'h0,
    parameter logic [31:0] C_SEED           = 32'h1,
    parameter int          C_TIMEOUT_CYCLES = 256
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      INIT_AXI_TXN,
    output logic                      TXN_DONE,
    output logic                      ERROR,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int IDX_W = $clog2(C_NUM_WORDS + 1);

    pm_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             init_q, init_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             txn_done_q, txn_done_d;
    logic             error_q, error_d;

    logic                    w_start;
    logic                    w_last;
    logic                    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                    w_aw_fin, w_w_fin;
    logic                    w_wr_busy, w_rd_busy;
    logic                    w_rd_bad;
    logic                    w_wd_expire;
    logic [C_ADDR_WIDTH-1:0] w_addr;
    logic [C_DATA_WIDTH-1:0] w_exp_data;

    assign w_start   = INIT_AXI_TXN & ~init_q;
    assign w_last    = (idx_q == IDX_W'(C_NUM_WORDS));
    assign w_aw_hs   = awvalid_q & M_AXI_AWREADY;
    assign w_w_hs    = wvalid_q & M_AXI_WREADY;
    assign w_b_hs    = bready_q & M_AXI_BVALID;
    assign w_ar_hs   = arvalid_q & M_AXI_ARREADY;
    assign w_r_hs    = rready_q & M_AXI_RVALID;
    // A channel is finished once its VALID has dropped or handshakes right now.
    assign w_aw_fin  = ~awvalid_q | w_aw_hs;
    assign w_w_fin   = ~wvalid_q | w_w_hs;
    assign w_wr_busy = awvalid_q | wvalid_q | bready_q;
    assign w_rd_busy = arvalid_q | rready_q;

    assign w_addr     = C_ADDR_WIDTH'(C_BASE_ADDR) + (C_ADDR_WIDTH'(idx_q) << 2);
    assign w_exp_data = C_DATA_WIDTH'(C_SEED + 32'(idx_q));
    assign w_rd_bad   = (M_AXI_RDATA != w_exp_data) || (M_AXI_RRESP != AXI_RESP_OKAY);

`ifdef AXIL_PM_TIMEOUT_EN
    logic w_pending;
    logic w_any_hs;

    assign w_pending = w_wr_busy | w_rd_busy;
    assign w_any_hs  = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

    axil_pm_watchdog #(
        .C_LIMIT (C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_clr     (w_any_hs | ~w_pending),
        .i_en      (w_pending),
        .o_expired (w_wd_expire)
    );
`else
    assign w_wd_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        init_d     = INIT_AXI_TXN;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        txn_done_d = txn_done_q;
        error_d    = error_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    state_d    = ST_WRITE;
                    idx_d      = '0;
                    error_d    = 1'b0;
                    txn_done_d = 1'b0;
                end
            end
            ST_WRITE: begin
                if (!w_wr_busy) begin
                    if (w_last) begin
                        state_d = ST_READ;
                        idx_d   = '0;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end else begin
                    if (w_aw_hs) awvalid_d = 1'b0;
                    if (w_w_hs)  wvalid_d  = 1'b0;
                    if ((awvalid_q | wvalid_q) && w_aw_fin && w_w_fin) begin
                        bready_d = 1'b1;
                    end
                    if (w_b_hs) begin
                        bready_d = 1'b0;
                        idx_d    = idx_q + IDX_W'(1);
                        if (M_AXI_BRESP != AXI_RESP_OKAY) error_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (!w_rd_busy) begin
                    if (w_last) begin
                        state_d    = ST_DONE;
                        txn_done_d = 1'b1;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end else begin
                    if (w_ar_hs) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                    end
                    if (w_r_hs) begin
                        rready_d = 1'b0;
                        idx_d    = idx_q + IDX_W'(1);
                        if (w_rd_bad) error_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_wd_expire) begin
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            error_d    = 1'b1;
            txn_done_d = 1'b1;
            state_d    = ST_DONE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            init_q     <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            txn_done_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            init_q     <= init_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            txn_done_q <= txn_done_d;
            error_q    <= error_d;
        end
    end

    assign TXN_DONE      = txn_done_q;
    assign ERROR         = error_q;
    assign M_AXI_AWADDR  = w_addr;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = w_exp_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = w_addr;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_pattern_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_pattern_master
// Brief    : Self-checking bench: memory slave with randomised/fixed ready and
//            response delays, fault injection and a behavioural pattern model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axil_pattern_master;

    localparam int          NW   = 4;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] SEED = 32'h1;
`ifdef AXIL_PM_TIMEOUT_EN
    localparam int          TMO  = 16;
`else
    localparam int          TMO  = 256;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init = 1'b0;
    logic        txn_done, error;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'h0;

    always #5 clk = ~clk;

    axil_pattern_master #(
        .C_ADDR_WIDTH     (32),
        .C_DATA_WIDTH     (32),
        .C_NUM_WORDS      (NW),
        .C_BASE_ADDR      (BASE),
        .C_SEED           (SEED),
        .C_TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .INIT_AXI_TXN  (init),
        .TXN_DONE      (txn_done),
        .ERROR         (error),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave configuration and fault injection
    int          max_dly   = 0;
    int          cfg_aw    = 0;
    int          cfg_w     = 0;
    int          bresp_err_word = -1;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'h0;
    bit          ar_block  = 1'b0;

    // Behavioural model state
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit err_model = 1'b0;
    bit track = 1'b0;
    int arvalid_cycles = 0;

    logic [31:0] mem [0:255];

    function automatic int pick(input int cfg);
        if (max_dly > 0) return int'($urandom_range(max_dly, 0));
        return cfg;
    endfunction

    // Handshakes observed at each rising edge, consumed by the slave on the falling edge
    logic        aw_hs_s = 1'b0, w_hs_s = 1'b0, b_hs_s = 1'b0, ar_hs_s = 1'b0, r_hs_s = 1'b0;
    logic [31:0] aw_addr_s = 32'h0, w_data_s = 32'h0, ar_addr_s = 32'h0;

    always @(posedge clk) begin
        aw_hs_s   <= awvalid & awready;
        w_hs_s    <= wvalid & wready;
        b_hs_s    <= bvalid & bready;
        ar_hs_s   <= arvalid & arready;
        r_hs_s    <= rvalid & rready;
        aw_addr_s <= awaddr;
        w_data_s  <= wdata;
        ar_addr_s <= araddr;
    end

    // Memory slave + per-cycle compare against the model
    initial begin : slave_and_compare
        bit          aw_got, w_got, ar_got, b_pend, r_pend;
        logic [31:0] aw_a, w_d, ar_a;
        int          aw_cnt, w_cnt, aw_dly, w_dly, b_wait, r_wait;
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
        aw_a = 0; w_d = 0; ar_a = 0;
        aw_cnt = 0; w_cnt = 0; aw_dly = 0; w_dly = 0; b_wait = 0; r_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rresp = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0;
                wr_cnt = 0; rd_cnt = 0;
            end else begin
                if (aw_hs_s) begin
                    chk("aw_hs_addr", aw_addr_s, BASE + 32'(4 * wr_cnt));
                    aw_got = 1; aw_a = aw_addr_s;
                end
                if (w_hs_s) begin
                    chk("w_hs_data", w_data_s, SEED + 32'(wr_cnt));
                    w_got = 1; w_d = w_data_s;
                end
                if (b_hs_s) begin
                    if (bresp != 2'b00) err_model = 1;
                    bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0;
                    wr_cnt++;
                end
                if (ar_hs_s) begin
                    chk("ar_hs_addr", ar_addr_s, BASE + 32'(4 * rd_cnt));
                    ar_got = 1; ar_a = ar_addr_s; r_pend = 1; r_wait = pick(0);
                end
                if (r_hs_s) begin
                    if (rdata !== SEED + 32'(rd_cnt) || rresp != 2'b00) err_model = 1;
                    rvalid = 0; r_pend = 0; ar_got = 0;
                    rd_cnt++;
                end

                if (aw_got && w_got && !b_pend) begin
                    mem[aw_a[9:2]] = w_d;
                    b_pend = 1;
                    b_wait = pick(0);
                    bresp  = (wr_cnt == bresp_err_word) ? 2'b10 : 2'b00;
                end
                if (b_pend && !bvalid) begin
                    if (b_wait == 0) bvalid = 1;
                    else b_wait--;
                end
                if (r_pend && !rvalid) begin
                    if (r_wait == 0) begin
                        rvalid = 1;
                        rresp  = 2'b00;
                        rdata  = (corrupt_en && ar_a == corrupt_addr) ? 32'hDEAD : mem[ar_a[9:2]];
                    end else begin
                        r_wait--;
                    end
                end

                if (awvalid && !aw_got) begin
                    if (aw_cnt == 0) aw_dly = pick(cfg_aw);
                    awready = (aw_cnt >= aw_dly);
                    aw_cnt++;
                end else begin
                    awready = 0; aw_cnt = 0;
                end
                if (wvalid && !w_got) begin
                    if (w_cnt == 0) w_dly = pick(cfg_w);
                    wready = (w_cnt >= w_dly);
                    w_cnt++;
                end else begin
                    wready = 0; w_cnt = 0;
                end
                arready = arvalid && !ar_got && !ar_block && ($urandom_range(max_dly, 0) == 0);

                if (awvalid) begin
                    chk("awaddr", awaddr, BASE + 32'(4 * wr_cnt));
                    chk("awprot", 32'(awprot), 32'h0);
                end
                if (wvalid) begin
                    chk("wdata", wdata, SEED + 32'(wr_cnt));
                    chk("wstrb", 32'(wstrb), 32'hF);
                end
                if (bready)  chk("bready_after_aw_w", 32'(aw_got && w_got), 32'h1);
                if (arvalid) begin
                    arvalid_cycles++;
                    chk("araddr", araddr, BASE + 32'(4 * rd_cnt));
                    chk("arprot", 32'(arprot), 32'h0);
                    chk("no_write_during_read", 32'(awvalid | wvalid | bready), 32'h0);
                end
                if (rready) chk("rready_after_ar", 32'(ar_got), 32'h1);
                if (track)  chk("error_tracks_model", 32'(error), 32'(err_model));
            end
        end
    end

    task automatic run_txn(input bit poke_read, input bit do_track, output int cyc);
        bit poked;
        poked  = 0;
        wr_cnt = 0;
        rd_cnt = 0;
        @(posedge clk); #2 init = 1;
        @(posedge clk); #2 init = 0;
        err_model = 0;
        track     = do_track;
        chk("start_clears_done", 32'(txn_done), 32'h0);
        chk("start_clears_error", 32'(error), 32'h0);
        cyc = 0;
        while (!txn_done && cyc < 3000) begin
            @(posedge clk); #2;
            cyc++;
            if (init) init = 0;
            else if (poke_read && !poked && arvalid) begin
                init  = 1;
                poked = 1;
            end
        end
        init  = 0;
        track = 0;
        chk("txn_done_reached", 32'(txn_done), 32'h1);
    endtask

    task automatic clear_faults();
        max_dly = 0; cfg_aw = 0; cfg_w = 0;
        bresp_err_word = -1; corrupt_en = 0; ar_block = 0;
    endtask

    initial begin : stimulus
        int cyc;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        clear_faults();

        repeat (3) @(posedge clk);
        #2;
        chk("rst_awvalid", 32'(awvalid), 32'h0);
        chk("rst_wvalid", 32'(wvalid), 32'h0);
        chk("rst_bready", 32'(bready), 32'h0);
        chk("rst_arvalid", 32'(arvalid), 32'h0);
        chk("rst_rready", 32'(rready), 32'h0);
        chk("rst_txn_done", 32'(txn_done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        rst = 0;
        repeat (2) @(posedge clk);

        // Zero-wait pass
        run_txn(0, 1, cyc);
        chk("zw_cycles", 32'(cyc), 32'd26);
        chk("zw_error", 32'(error), 32'h0);
        chk("zw_writes", 32'(wr_cnt), 32'd4);
        chk("zw_reads", 32'(rd_cnt), 32'd4);
        chk("zw_mem0", mem[0], 32'h1);
        chk("zw_mem1", mem[1], 32'h2);
        chk("zw_mem2", mem[2], 32'h3);
        chk("zw_mem3", mem[3], 32'h4);

        // Corrupted read at 0x8
        corrupt_en = 1; corrupt_addr = 32'h8;
        run_txn(0, 1, cyc);
        chk("bad_rd_error", 32'(error), 32'h1);
        chk("bad_rd_reads", 32'(rd_cnt), 32'd4);
        clear_faults();

        // Error response on write word 1
        bresp_err_word = 1;
        run_txn(0, 1, cyc);
        chk("bresp_error", 32'(error), 32'h1);
        chk("bresp_writes", 32'(wr_cnt), 32'd4);
        chk("bresp_reads", 32'(rd_cnt), 32'd4);
        clear_faults();

        // Skewed AW/W readiness, both orders
        cfg_aw = 0; cfg_w = 3;
        run_txn(0, 1, cyc);
        chk("skew_aw_first_error", 32'(error), 32'h0);
        chk("skew_aw_first_mem3", mem[3], 32'h4);
        cfg_aw = 3; cfg_w = 0;
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        run_txn(0, 1, cyc);
        chk("skew_w_first_error", 32'(error), 32'h0);
        chk("skew_w_first_mem1", mem[1], 32'h2);
        clear_faults();

        // Start pulse during READ is ignored
        run_txn(1, 1, cyc);
        chk("poke_writes", 32'(wr_cnt), 32'd4);
        chk("poke_reads", 32'(rd_cnt), 32'd4);
        chk("poke_error", 32'(error), 32'h0);

        // Randomised delays and faults
        for (int r = 0; r < 8; r++) begin
            max_dly        = 4;
            corrupt_en     = ($urandom_range(2, 0) == 0);
            corrupt_addr   = BASE + 32'(4 * $urandom_range(NW - 1, 0));
            bresp_err_word = ($urandom_range(2, 0) == 0) ? int'($urandom_range(NW - 1, 0)) : -1;
            run_txn(0, 1, cyc);
            chk("rnd_error", 32'(error), 32'(err_model));
            chk("rnd_writes", 32'(wr_cnt), 32'd4);
            chk("rnd_reads", 32'(rd_cnt), 32'd4);
        end
        clear_faults();

        // Reset in the middle of a write
        cfg_w = 5;
        @(posedge clk); #2 init = 1;
        @(posedge clk); #2 init = 0;
        n = 0;
        while (!awvalid && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("mid_wr_awvalid_seen", 32'(awvalid), 32'h1);
        rst = 1;
        @(posedge clk); #2;
        chk("mid_rst_awvalid", 32'(awvalid), 32'h0);
        chk("mid_rst_wvalid", 32'(wvalid), 32'h0);
        chk("mid_rst_bready", 32'(bready), 32'h0);
        chk("mid_rst_arvalid", 32'(arvalid), 32'h0);
        chk("mid_rst_rready", 32'(rready), 32'h0);
        chk("mid_rst_txn_done", 32'(txn_done), 32'h0);
        chk("mid_rst_error", 32'(error), 32'h0);
        @(posedge clk); #2 rst = 0;
        clear_faults();
        repeat (2) @(posedge clk);
        run_txn(0, 1, cyc);
        chk("post_rst_cycles", 32'(cyc), 32'd26);
        chk("post_rst_error", 32'(error), 32'h0);

`ifdef AXIL_PM_TIMEOUT_EN
        // Slave never accepts the read address
        ar_block = 1;
        arvalid_cycles = 0;
        run_txn(0, 0, cyc);
        chk("tmo_error", 32'(error), 32'h1);
        chk("tmo_arvalid", 32'(arvalid), 32'h0);
        chk("tmo_done", 32'(txn_done), 32'h1);
        chk("tmo_stall_cycles", 32'(arvalid_cycles), 32'd16);
        @(posedge clk); #2;
        rst = 1;
        @(posedge clk); #2 rst = 0;
        clear_faults();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : global_timeout
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
